pipe_mux: RTL and testbench

PIPE_MUX -- requirements
Module: pipe_mux

---
 rtl/pipe_mux.sv | 139 +++++++++++++
 tb/tb_pipe_mux.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mux.sv
// rtl/pipe_mux.sv - registered channel mux with a 2-entry skid buffer on its output
// The main register drives the outputs and the skid register catches the word accepted in the cycle that stalls.
module pipe_mux #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   main_data_q, main_data_d;
    logic [SEL_W-1:0]   main_sel_q,  main_sel_d;
    logic [WIDTH-1:0]   skid_data_q, skid_data_d;
    logic [SEL_W-1:0]   skid_sel_q,  skid_sel_d;
    logic               in_ready_q,  in_ready_d;
    logic               sel_err_q,   sel_err_d;
    logic               out_valid_c;

    logic [WIDTH-1:0]   cap_data;
    logic               sel_oor;
    logic               accept;
    logic               pop;

    assign accept = in_valid && in_ready_q;
    assign pop    = out_valid_c && out_ready;

    // An unmatched select captures zeros and is flagged as out of range.
    always_comb begin
        cap_data = '0;
        sel_oor  = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                cap_data = in_data[i*WIDTH +: WIDTH];
                sel_oor  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (accept) state_d = ONE;
            ONE: begin
                if (accept && !pop)      state_d = FULL;
                else if (!accept && pop) state_d = EMPTY;
            end
            FULL:    if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        out_valid_c = (state_q != EMPTY);
    end

    always_comb begin
        main_data_d = main_data_q;
        main_sel_d  = main_sel_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
        sel_err_d   = sel_err_q || (accept && sel_oor);
        // Registered ready looks at the next state so it never depends on out_ready combinationally.
        in_ready_d  = (state_d != FULL);
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_data_d = cap_data;
                    main_sel_d  = sel;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    main_data_d = cap_data;
                    main_sel_d  = sel;
                end else if (accept) begin
                    skid_data_d = cap_data;
                    skid_sel_d  = sel;
                end
            end
            FULL: begin
                if (pop) begin
                    main_data_d = skid_data_q;
                    main_sel_d  = skid_sel_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data_q <= '0;
            main_sel_q  <= '0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
            in_ready_q  <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            main_data_q <= main_data_d;
            main_sel_q  <= main_sel_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
            in_ready_q  <= in_ready_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = main_data_q;
    assign out_sel   = main_sel_q;
    assign out_valid = out_valid_c;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_pipe_mux.sv
// tb/tb_pipe_mux.sv - scoreboard bench for pipe_mux (4-channel x32 and 3-channel x8 instances)
module tb_pipe_mux;

    logic         clk;
    logic         rst_n;

    logic [31:0]  ch [4];
    logic [127:0] in_data0;
    logic [1:0]   sel0;
    logic         in_valid0;
    logic         in_ready0;
    logic [31:0]  out_data0;
    logic [1:0]   out_sel0;
    logic         out_valid0;
    logic         out_ready0;
    logic         sel_err0;

    logic [23:0]  in_data1;
    logic [1:0]   sel1;
    logic         in_valid1;
    logic         in_ready1;
    logic [7:0]   out_data1;
    logic [1:0]   out_sel1;
    logic         out_valid1;
    logic         out_ready1;
    logic         sel_err1;

    int checks = 0;
    int errors = 0;

    assign in_data0 = {ch[3], ch[2], ch[1], ch[0]};
    assign in_data1 = {8'h33, 8'h22, 8'h11};

    pipe_mux #(.WIDTH(32), .NUM_IN(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data0), .sel(sel0),
        .in_valid(in_valid0), .in_ready(in_ready0), .out_data(out_data0),
        .out_sel(out_sel0), .out_valid(out_valid0), .out_ready(out_ready0),
        .sel_err(sel_err0)
    );

    pipe_mux #(.WIDTH(8), .NUM_IN(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data1), .sel(sel1),
        .in_valid(in_valid1), .in_ready(in_ready1), .out_data(out_data1),
        .out_sel(out_sel1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sel_err(sel_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [1:0]  s;
        logic [31:0] d;
    } exp_t;

    exp_t        exp_q [$];
    exp_t        e;
    int          cnt = 0;
    int          pop_count = 0;
    bit          prev_rst = 1'b0;
    bit          hold = 1'b0;
    logic [31:0] hold_data;
    logic [1:0]  hold_sel;
    int          acc, pp;

    // Monitor/scoreboard for instance 0: occupancy model, FIFO order and hold stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", 64'(out_valid0), 64'd0);
            chk("rst_in_ready", 64'(in_ready0), 64'd0);
            exp_q.delete();
            cnt      = 0;
            hold     = 1'b0;
            prev_rst = 1'b0;
        end else begin
            if (prev_rst) begin
                chk("model_out_valid", 64'(out_valid0), 64'(cnt != 0));
                chk("model_in_ready", 64'(in_ready0), 64'(cnt != 2));
                if (hold) begin
                    chk("hold_valid", 64'(out_valid0), 64'd1);
                    chk("hold_data", 64'(out_data0), 64'(hold_data));
                    chk("hold_sel", 64'(out_sel0), 64'(hold_sel));
                end
            end
            acc = (in_valid0 && in_ready0) ? 1 : 0;
            pp  = (out_valid0 && out_ready0) ? 1 : 0;
            if (pp != 0) begin
                pop_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_pop: got %0h expected no word", out_data0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_data", 64'(out_data0), 64'(e.d));
                    chk("sb_sel", 64'(out_sel0), 64'(e.s));
                end
            end
            if (acc != 0) exp_q.push_back('{s: sel0, d: ch[sel0]});
            hold      = out_valid0 && !out_ready0;
            hold_data = out_data0;
            hold_sel  = out_sel0;
            cnt       = cnt + acc - pp;
            prev_rst  = 1'b1;
        end
    end

    task automatic drain();
        int n;
        in_valid0  = 1'b0;
        out_ready0 = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || out_valid0) && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d words left expected 0", exp_q.size());
        end
        step();
    endtask

    initial begin
        int base;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) ch[i] = '0;
        sel0 = '0; in_valid0 = 1'b0; out_ready0 = 1'b0;
        sel1 = '0; in_valid1 = 1'b0; out_ready1 = 1'b1;
        #1;
        chk("reset_out_data", 64'(out_data0), 64'd0);
        chk("reset_out_sel", 64'(out_sel0), 64'd0);
        chk("reset_sel_err", 64'(sel_err0), 64'd0);
        chk("reset_out_valid", 64'(out_valid0), 64'd0);
        chk("reset_in_ready", 64'(in_ready0), 64'd0);
        step(); step();
        rst_n = 1'b1;
        #1;
        chk("release_in_ready_low", 64'(in_ready0), 64'd0);
        step();
        chk("release_in_ready_high", 64'(in_ready0), 64'd1);

        // Basic select
        ch[0] = 32'h0000ffff; ch[1] = 32'haaaa0000;
        sel0 = 2'd1; in_valid0 = 1'b1; out_ready0 = 1'b1;
        step();
        chk("basic_data1", 64'(out_data0), 64'haaaa0000);
        chk("basic_sel1", 64'(out_sel0), 64'd1);
        chk("basic_valid1", 64'(out_valid0), 64'd1);
        sel0 = 2'd0;
        step();
        chk("basic_data0", 64'(out_data0), 64'h0000ffff);
        chk("basic_sel0", 64'(out_sel0), 64'd0);
        in_valid0 = 1'b0;
        step();
        chk("basic_empty", 64'(out_valid0), 64'd0);

        // Backpressure: A, B fill the buffer, C waits
        out_ready0 = 1'b0; sel0 = 2'd2; in_valid0 = 1'b1; ch[2] = 32'hA0A0A0A0;
        step();
        chk("bp_ready_after_a", 64'(in_ready0), 64'd1);
        ch[2] = 32'hB1B1B1B1;
        step();
        chk("bp_ready_after_b", 64'(in_ready0), 64'd0);
        chk("bp_data_a", 64'(out_data0), 64'hA0A0A0A0);
        ch[2] = 32'hC2C2C2C2;
        step();
        chk("bp_hold_ready", 64'(in_ready0), 64'd0);
        chk("bp_hold_data", 64'(out_data0), 64'hA0A0A0A0);
        step();
        chk("bp_hold_data2", 64'(out_data0), 64'hA0A0A0A0);
        out_ready0 = 1'b1;
        step();
        chk("bp_out_b", 64'(out_data0), 64'hB1B1B1B1);
        chk("bp_ready_back", 64'(in_ready0), 64'd1);
        step();
        chk("bp_out_c", 64'(out_data0), 64'hC2C2C2C2);
        in_valid0 = 1'b0;
        step();
        chk("bp_empty", 64'(out_valid0), 64'd0);

        // Throughput: 16 back-to-back words
        base = pop_count;
        out_ready0 = 1'b1; in_valid0 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sel0 = 2'(i);
            ch[i % 4] = 32'h1000_0000 + 32'(i);
            step();
            chk("tp_in_ready", 64'(in_ready0), 64'd1);
            chk("tp_out_valid", 64'(out_valid0), 64'd1);
        end
        in_valid0 = 1'b0;
        step();
        chk("tp_pop_count", 64'(pop_count - base), 64'd16);
        chk("tp_sel_err", 64'(sel_err0), 64'd0);

        // Out-of-range select on the 3-channel instance
        chk("oor_err_init", 64'(sel_err1), 64'd0);
        sel1 = 2'd3; in_valid1 = 1'b1;
        step();
        chk("oor_data", 64'(out_data1), 64'd0);
        chk("oor_sel", 64'(out_sel1), 64'd3);
        chk("oor_valid", 64'(out_valid1), 64'd1);
        chk("oor_err", 64'(sel_err1), 64'd1);
        sel1 = 2'd2;
        step();
        chk("oor_legal2", 64'(out_data1), 64'h33);
        chk("oor_err_sticky2", 64'(sel_err1), 64'd1);
        sel1 = 2'd0;
        step();
        chk("oor_legal0", 64'(out_data1), 64'h11);
        chk("oor_err_sticky0", 64'(sel_err1), 64'd1);
        in_valid1 = 1'b0;
        step();

        // Reset with two words buffered
        out_ready0 = 1'b0; in_valid0 = 1'b1; sel0 = 2'd3; ch[3] = 32'hDEAD0001;
        step();
        ch[3] = 32'hDEAD0002;
        step();
        in_valid0 = 1'b0;
        chk("mr_full_ready", 64'(in_ready0), 64'd0);
        chk("mr_full_valid", 64'(out_valid0), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_out_valid", 64'(out_valid0), 64'd0);
        chk("mr_in_ready", 64'(in_ready0), 64'd0);
        chk("mr_out_data", 64'(out_data0), 64'd0);
        chk("mr_sel_err_clr", 64'(sel_err1), 64'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("mr_release_low", 64'(in_ready0), 64'd0);
        step();
        chk("mr_release_high", 64'(in_ready0), 64'd1);
        out_ready0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mr_no_stale", 64'(out_valid0), 64'd0);
        end

        // Random handshakes against the scoreboard
        for (int i = 0; i < 10000; i++) begin
            in_valid0  = 1'($urandom_range(0, 1));
            out_ready0 = 1'($urandom_range(0, 1));
            sel0       = 2'($urandom_range(0, 3));
            for (int j = 0; j < 4; j++) ch[j] = $urandom;
            step();
        end
        drain();
        chk("final_sel_err", 64'(sel_err0), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
